// File: rtl/reg_arb.sv
// Two-master round-robin arbiter for the 8-bit-address / 32-bit-data register bus.
// The host bridge (m0) and a debug/console master (m1) share one register slave.
// Each slave transaction is bounded by a timeout so a dead slave cannot hang a master.
module reg_arb #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  // master 0 (host bridge)
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  // master 1 (debug/console)
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  // register slave port
  output logic          s_req,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_ack,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_err,
  // status
  output logic          busy,
  output logic          timeout
);

  // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits are enough.
  localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            ptr_q;
  logic            gnt_q;
  logic [CNTW-1:0] cnt_q;

  logic            s_req_q;
  logic            s_wr_q;
  logic [AW-1:0]   s_addr_q;
  logic [DW-1:0]   s_wdata_q;
  logic            m0_ack_q;
  logic            m1_ack_q;
  logic [DW-1:0]   m0_rdata_q;
  logic [DW-1:0]   m1_rdata_q;
  logic            m0_err_q;
  logic            m1_err_q;
  logic            busy_q;
  logic            timeout_q;

  logic            gnt_vld_d;
  logic            gnt_idx_d;

  // Grant decision: a lone requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt_vld_d = m0_req | m1_req;
    gnt_idx_d = 1'b0;
    if (m0_req && m1_req) begin
      gnt_idx_d = ptr_q;
    end else if (m1_req) begin
      gnt_idx_d = 1'b1;
    end
  end

  // Transaction FSM with all bus/status outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      s_req_q    <= 1'b0;
      s_wr_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_d) begin
            gnt_q     <= gnt_idx_d;
            s_wr_q    <= gnt_idx_d ? m1_wr    : m0_wr;
            s_addr_q  <= gnt_idx_d ? m1_addr  : m0_addr;
            s_wdata_q <= gnt_idx_d ? m1_wdata : m0_wdata;
            s_req_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          s_req_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A slave ack on the expiry cycle still counts as a normal response.
          if (s_ack) begin
            if (gnt_q) begin
              m1_rdata_q <= s_rdata;
              m1_err_q   <= s_err;
              m1_ack_q   <= 1'b1;
            end else begin
              m0_rdata_q <= s_rdata;
              m0_err_q   <= s_err;
              m0_ack_q   <= 1'b1;
            end
            state_q <= RESP;
          end else if (cnt_q == CNT_MAX) begin
            if (gnt_q) begin
              m1_rdata_q <= '0;
              m1_err_q   <= 1'b1;
              m1_ack_q   <= 1'b1;
            end else begin
              m0_rdata_q <= '0;
              m0_err_q   <= 1'b1;
              m0_ack_q   <= 1'b1;
            end
            timeout_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          m0_ack_q  <= 1'b0;
          m1_ack_q  <= 1'b0;
          timeout_q <= 1'b0;
          ptr_q     <= ~gnt_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_req    = s_req_q;
  assign s_wr     = s_wr_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
